// File: rtl/norm_shift16_pkg.sv
// Shared constants for the post-subtract normalizer and its leading-zero anticipator.
// D_WIDTH   : magnitude width of the difference being normalized.
// E_WIDTH   : exponent width.
// CNT_WIDTH : predicted shift-count width from the anticipator.
// TOT_WIDTH : width of predicted count plus the one-position correction (0..D_WIDTH).
package norm_shift16_pkg;

  localparam int unsigned D_WIDTH   = 16;
  localparam int unsigned E_WIDTH   = 8;
  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned TOT_WIDTH = CNT_WIDTH + 1;

endpackage

// File: rtl/norm_shift16_if.sv
// Stream interface of the normalizer: input beat (magnitude, exponent, anticipator
// prediction) with valid/ready, and result beat (normalized magnitude, exponent, flags)
// with valid/ready.
// master : producer of input beats and consumer of results (e.g. the surrounding datapath).
// slave  : the normalizer itself.
interface norm_shift16_if #(
  parameter int unsigned D_WIDTH   = norm_shift16_pkg::D_WIDTH,
  parameter int unsigned E_WIDTH   = norm_shift16_pkg::E_WIDTH,
  parameter int unsigned CNT_WIDTH = norm_shift16_pkg::CNT_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [D_WIDTH-1:0]   in_mag;
  logic [E_WIDTH-1:0]   in_exp;
  logic [CNT_WIDTH-1:0] in_sft_cnt;
  logic                 in_correct;
  logic                 in_zero;

  logic                 out_valid;
  logic                 out_ready;
  logic [D_WIDTH-1:0]   out_mag;
  logic [E_WIDTH-1:0]   out_exp;
  logic                 out_zero;
  logic                 out_uf;
  logic                 out_err;

  modport master (
    output in_valid, in_mag, in_exp, in_sft_cnt, in_correct, in_zero, out_ready,
    input  in_ready, out_valid, out_mag, out_exp, out_zero, out_uf, out_err
  );

  modport slave (
    input  in_valid, in_mag, in_exp, in_sft_cnt, in_correct, in_zero, out_ready,
    output in_ready, out_valid, out_mag, out_exp, out_zero, out_uf, out_err
  );

endinterface

// File: rtl/norm_shift16_lsh16.sv
// lsh16: combinational logarithmic left barrel shifter.
// data_i : value to shift.
// amt_i  : shift amount; bit i selects a shift by 2**i in stage i.
// data_o : data_i << amt_i, zero filled.
module lsh16 #(
  parameter int unsigned D_WIDTH   = norm_shift16_pkg::D_WIDTH,
  parameter int unsigned CNT_WIDTH = norm_shift16_pkg::CNT_WIDTH
) (
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic [CNT_WIDTH-1:0] amt_i,
  output logic [D_WIDTH-1:0]   data_o
);

  logic [D_WIDTH-1:0] stg [CNT_WIDTH+1];

  assign stg[0] = data_i;

  for (genvar i = 0; i < CNT_WIDTH; i++) begin : g_stage
    assign stg[i+1] = amt_i[i] ? (stg[i] << (2 ** i)) : stg[i];
  end

  assign data_o = stg[CNT_WIDTH];

endmodule

// File: rtl/norm_shift16.sv
// norm_shift16: two-stage normalizer for an effective-subtract result.
// Stage 1 coarse-shifts the magnitude by the anticipator's predicted count; stage 2 applies
// the one-position correction, adjusts the exponent and resolves zero/underflow/error flags.
// clk, rst : clock and asynchronous active-high reset.
// bus      : slave side of norm_shift16_if (input beat and result beat, valid/ready each).
module norm_shift16 #(
  parameter int unsigned D_WIDTH   = norm_shift16_pkg::D_WIDTH,
  parameter int unsigned E_WIDTH   = norm_shift16_pkg::E_WIDTH,
  parameter int unsigned CNT_WIDTH = norm_shift16_pkg::CNT_WIDTH
) (
  input logic           clk,
  input logic           rst,
  norm_shift16_if.slave bus
);

  import norm_shift16_pkg::*;

  localparam int unsigned TotWidth = CNT_WIDTH + 1;
  localparam logic [TotWidth-1:0] FullShift = TotWidth'(D_WIDTH);

  logic                 s2_adv, s1_adv;
  logic [D_WIDTH-1:0]   coarse_mag;

  logic                 s1_valid_q, s1_valid_d;
  logic [D_WIDTH-1:0]   s1_mag_q, s1_mag_d;
  logic [E_WIDTH-1:0]   s1_exp_q, s1_exp_d;
  logic [CNT_WIDTH-1:0] s1_cnt_q, s1_cnt_d;
  logic                 s1_correct_q, s1_correct_d;
  logic                 s1_zero_q, s1_zero_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [D_WIDTH-1:0]   out_mag_q, out_mag_d;
  logic [E_WIDTH-1:0]   out_exp_q, out_exp_d;
  logic                 out_zero_q, out_zero_d;
  logic                 out_uf_q, out_uf_d;
  logic                 out_err_q, out_err_d;

  logic [TotWidth-1:0]  tot_shift;
  logic [E_WIDTH-1:0]   tot_shift_ext;
  logic [D_WIDTH-1:0]   fine_mag;

  lsh16 #(
    .D_WIDTH  (D_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_lsh16 (
    .data_i(bus.in_mag),
    .amt_i (bus.in_sft_cnt),
    .data_o(coarse_mag)
  );

  // No skid buffer: in_ready depends combinationally on out_ready.
  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_mag_d     = s1_mag_q;
    s1_exp_d     = s1_exp_q;
    s1_cnt_d     = s1_cnt_q;
    s1_correct_d = s1_correct_q;
    s1_zero_d    = s1_zero_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_mag_d     = coarse_mag;
        s1_exp_d     = bus.in_exp;
        s1_cnt_d     = bus.in_sft_cnt;
        s1_correct_d = bus.in_correct;
        s1_zero_d    = bus.in_zero;
      end
    end
  end

  always_comb begin
    tot_shift     = {1'b0, s1_cnt_q} + TotWidth'(s1_correct_q);
    tot_shift_ext = E_WIDTH'(tot_shift);
    fine_mag      = s1_correct_q ? (s1_mag_q << 1) : s1_mag_q;

    s2_valid_d = s2_valid_q;
    out_mag_d  = out_mag_q;
    out_exp_d  = out_exp_q;
    out_zero_d = out_zero_q;
    out_uf_d   = out_uf_q;
    out_err_d  = out_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_mag_d  = '0;
        out_exp_d  = '0;
        out_zero_d = 1'b0;
        out_uf_d   = 1'b0;
        out_err_d  = 1'b0;
        if (s1_zero_q) begin
          out_zero_d = 1'b1;
        end else if (s1_exp_q <= tot_shift_ext) begin
          out_uf_d = 1'b1;
        end else if (tot_shift == FullShift) begin
          // Everything shifted out: exact zero, exponent still tracks the shift.
          out_zero_d = 1'b1;
          out_exp_d  = s1_exp_q - tot_shift_ext;
        end else begin
          out_mag_d = fine_mag;
          out_exp_d = s1_exp_q - tot_shift_ext;
          out_err_d = !fine_mag[D_WIDTH-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_mag_q     <= '0;
      s1_exp_q     <= '0;
      s1_cnt_q     <= '0;
      s1_correct_q <= 1'b0;
      s1_zero_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_mag_q    <= '0;
      out_exp_q    <= '0;
      out_zero_q   <= 1'b0;
      out_uf_q     <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mag_q     <= s1_mag_d;
      s1_exp_q     <= s1_exp_d;
      s1_cnt_q     <= s1_cnt_d;
      s1_correct_q <= s1_correct_d;
      s1_zero_q    <= s1_zero_d;
      s2_valid_q   <= s2_valid_d;
      out_mag_q    <= out_mag_d;
      out_exp_q    <= out_exp_d;
      out_zero_q   <= out_zero_d;
      out_uf_q     <= out_uf_d;
      out_err_q    <= out_err_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.out_mag   = out_mag_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_uf    = out_uf_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_norm_shift16.sv
// Self-checking bench for norm_shift16: scoreboard of expected result beats pushed on input
// transfer and popped on output transfer, plus directed latency/stall/reset checks.
module tb_norm_shift16;

  logic clk;
  logic rst;

  norm_shift16_if bus ();

  norm_shift16 dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned n_push;
  int unsigned n_pop;
  bit          rand_rdy;
  logic [26:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Expected result {mag[15:0], exp[7:0], zero, uf, err}.
  function automatic logic [26:0] model(input logic [15:0] mag, input logic [7:0] e,
                                        input logic [3:0] c, input logic corr,
                                        input logic z);
    int          tot;
    int          d;
    logic [31:0] w;
    tot = int'(c) + int'(corr);
    w   = {16'h0, mag} << tot;
    d   = int'(e) - tot;
    if (z) return {16'h0, 8'h0, 1'b1, 1'b0, 1'b0};
    if (d <= 0) return {16'h0, 8'h0, 1'b0, 1'b1, 1'b0};
    if (tot == 16) return {16'h0, 8'(d), 1'b1, 1'b0, 1'b0};
    return {w[15:0], 8'(d), 1'b0, 1'b0, !w[15]};
  endfunction

  task automatic send(input logic [15:0] mag, input logic [7:0] e, input logic [3:0] c,
                      input logic corr, input logic z);
    bit acc;
    bus.in_mag     = mag;
    bus.in_exp     = e;
    bus.in_sft_cnt = c;
    bus.in_correct = corr;
    bus.in_zero    = z;
    bus.in_valid   = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    check_eq("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (sb.size() != 0 || bus.out_valid); k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    n_push         = 0;
    n_pop          = 0;
    rand_rdy       = 1'b0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_mag     = '0;
    bus.in_exp     = '0;
    bus.in_sft_cnt = '0;
    bus.in_correct = 1'b0;
    bus.in_zero    = 1'b0;
    bus.out_ready  = 1'b1;

    fork
      // Monitor: pop before push so a beat never matches itself in the same cycle.
      forever begin
        @(negedge clk);
        if (rst) begin
          sb.delete();
          n_push = 0;
          n_pop  = 0;
        end else begin
          if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
              check_eq("spurious_out", 32'd1, 32'd0);
            end else begin
              check_eq("beat", 32'({bus.out_mag, bus.out_exp, bus.out_zero, bus.out_uf,
                                    bus.out_err}), 32'(sb.pop_front()));
            end
            n_pop++;
          end
          if (bus.in_valid && bus.in_ready) begin
            sb.push_back(model(bus.in_mag, bus.in_exp, bus.in_sft_cnt, bus.in_correct,
                               bus.in_zero));
            n_push++;
          end
        end
      end
      forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      end
    join_none

    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_mag", 32'(bus.out_mag), 32'd0);
    check_eq("rst_out_exp", 32'(bus.out_exp), 32'd0);
    check_eq("rst_out_flags", 32'({bus.out_zero, bus.out_uf, bus.out_err}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Latency: accepted at the first edge, result visible after the second.
    bus.in_mag     = 16'h00F0;
    bus.in_exp     = 8'd20;
    bus.in_sft_cnt = 4'd8;
    bus.in_correct = 1'b0;
    bus.in_zero    = 1'b0;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("lat_edge1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("lat_edge2_valid", 32'(bus.out_valid), 32'd1);
    check_eq("f000_mag", 32'(bus.out_mag), 32'h0000F000);
    check_eq("f000_exp", 32'(bus.out_exp), 32'd12);
    check_eq("f000_flags", 32'({bus.out_zero, bus.out_uf, bus.out_err}), 32'd0);

    // Directed corner beats, back to back.
    send(16'h0100, 8'd20, 4'd6, 1'b1, 1'b0);   // correction -> 8000, exp 13
    send(16'h1234, 8'd9, 4'd3, 1'b1, 1'b1);    // zero flag wins
    send(16'h0001, 8'd10, 4'd15, 1'b0, 1'b0);  // underflow
    send(16'h0010, 8'd30, 4'd10, 1'b0, 1'b0);  // misprediction -> err
    send(16'h0001, 8'd40, 4'd15, 1'b1, 1'b0);  // total shift 16 -> zero
    send(16'h00FF, 8'd8, 4'd8, 1'b0, 1'b0);    // exp == shift -> underflow
    send(16'h00FF, 8'd9, 4'd8, 1'b0, 1'b0);    // exp == shift+1 -> exp 1
    send(16'h8001, 8'd0, 4'd0, 1'b0, 1'b0);    // exp 0, no shift -> underflow
    drain();

    // Stall: both stages fill, in_ready drops, output holds.
    bus.out_ready = 1'b0;
    send(16'h0100, 8'd20, 4'd6, 1'b1, 1'b0);
    send(16'h00F0, 8'd20, 4'd8, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("stall_hold", 32'({bus.out_valid, bus.out_mag, bus.out_exp, bus.out_err}),
               32'({1'b1, 16'h8000, 8'd13, 1'b0}));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    drain();

    // Random ready with a reset pulse mid-stream.
    rand_rdy = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (b == 4) begin
        rst = 1'b1;
        #1;
        check_eq("rst_mid_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_mid_ready", 32'(bus.in_ready), 32'd1);
      end
      send(16'($urandom), 8'($urandom_range(0, 40)), 4'($urandom), 1'($urandom),
           1'($urandom_range(0, 7) == 0));
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    check_eq("beat_count", n_pop, n_push);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
